// File: rtl/id_sb_stage.sv
// Decode/scoreboard stage: single-entry holding register that issues an instruction once
// its source registers have no outstanding writes, with optional writeback forwarding.
module id_sb_stage #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned PEND_W = 2,
    parameter int unsigned BYPASS = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic            wb_en,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            rel_en,
    input  logic [4:0]      rel_rd,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_rs1_val,
    output logic [XLEN-1:0] out_rs2_val,
    output logic [4:0]      out_rd,
    output logic            stall,
    output logic            done
);

    localparam int unsigned NREG = 32;
    localparam int unsigned CW   = PEND_W + 1;
    localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};
    localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);
    localparam logic [31:0] HALT_WORD = 32'hdead10cc;
    localparam logic BYP = (BYPASS != 0);

    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_AUIPC  = 5'b00101;
    localparam logic [4:0] OPC_JAL    = 5'b11011;
    localparam logic [4:0] OPC_OP     = 5'b01100;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;

    logic            valid_q, valid_d;
    logic [31:0]     instr_q, instr_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];
    logic [PEND_W-1:0] pend_q [NREG];
    logic [PEND_W-1:0] pend_d [NREG];

    logic [4:0] opcode, rs1, rs2, rd;
    logic       rs1_used, rs2_used, rd_wr;
    logic       fwd1, fwd2, haz1, haz2, sat;
    logic       receive, send;
    logic [CW-1:0] up, dn;

    // Operand usage decode from the held instruction
    assign opcode   = instr_q[6:2];
    assign rs1      = instr_q[19:15];
    assign rs2      = instr_q[24:20];
    assign rd       = instr_q[11:7];
    assign rs1_used = !(opcode == OPC_LUI || opcode == OPC_AUIPC || opcode == OPC_JAL);
    assign rs2_used = (opcode == OPC_OP) || (opcode == OPC_STORE) || (opcode == OPC_BRANCH);
    assign rd_wr    = !(opcode == OPC_STORE || opcode == OPC_BRANCH) && (rd != 5'd0);

    // Forward only when this writeback retires the last outstanding write to the source
    assign fwd1 = BYP && (rs1 != 5'd0) && (pend_q[rs1] == PEND_ONE) && wb_en && (wb_rd == rs1)
                  && !(rel_en && (rel_rd == rs1));
    assign fwd2 = BYP && (rs2 != 5'd0) && (pend_q[rs2] == PEND_ONE) && wb_en && (wb_rd == rs2)
                  && !(rel_en && (rel_rd == rs2));
    assign haz1 = rs1_used && (rs1 != 5'd0) && (pend_q[rs1] != '0) && !fwd1;
    assign haz2 = rs2_used && (rs2 != 5'd0) && (pend_q[rs2] != '0) && !fwd2;
    assign sat  = rd_wr && (pend_q[rd] == PEND_MAX)
                  && !((wb_en && (wb_rd == rd)) || (rel_en && (rel_rd == rd)));

    assign stall     = valid_q && (haz1 || haz2 || sat);
    assign out_valid = valid_q && !stall && !flush;
    assign send      = out_valid && out_ready;
    assign in_ready  = !valid_q || send;
    assign receive   = in_valid && in_ready;

    assign out_instr   = instr_q;
    assign out_pc      = pc_q;
    assign out_rd      = rd;
    assign out_rs1_val = fwd1 ? wb_data : regs_q[rs1];
    assign out_rs2_val = fwd2 ? wb_data : regs_q[rs2];
    assign done        = valid_q && (instr_q == HALT_WORD);

    always_comb begin
        valid_d = flush ? 1'b0 : (receive || (valid_q && !send));
        instr_d = receive ? in_instr : instr_q;
        pc_d    = receive ? in_pc : pc_q;
    end

    // Register file writes and pending-count updates; x0 entries stay at zero
    always_comb begin
        up = '0;
        dn = '0;
        for (int r = 0; r < int'(NREG); r++) begin
            regs_d[r] = regs_q[r];
            pend_d[r] = pend_q[r];
        end
        for (int r = 1; r < int'(NREG); r++) begin
            up = {1'b0, pend_q[r]} + CW'(send && rd_wr && (rd == 5'(r)));
            dn = CW'(wb_en && (wb_rd == 5'(r))) + CW'(rel_en && (rel_rd == 5'(r)));
            pend_d[r] = (up < dn) ? '0 : PEND_W'(up - dn);
            if (wb_en && (wb_rd == 5'(r))) begin
                regs_d[r] = wb_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            pc_q    <= '0;
            for (int r = 0; r < int'(NREG); r++) begin
                regs_q[r] <= '0;
                pend_q[r] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
            for (int r = 0; r < int'(NREG); r++) begin
                regs_q[r] <= regs_d[r];
                pend_q[r] <= pend_d[r];
            end
        end
    end

endmodule
